// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, and long-latency results
// queue in a small FIFO that drains into idle cycles. A starvation counter forces a stall.
`ifndef XLEN
`define XLEN 32
`endif

module regfile_write_arbiter #(
    parameter int XLEN     = `XLEN,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_write_enable,
    input  logic [4:0]                 wb_write_sel,
    input  logic [XLEN-1:0]            wb_write_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_sel,
    input  logic [XLEN-1:0]            lu_data,
    output logic                       rf_write_enable,
    output logic [4:0]                 rf_write_sel,
    output logic [XLEN-1:0]            rf_write_data,
    output logic                       arb_stall_req,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]      sel_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q;
    logic [WW-1:0]   wait_q;
    logic            rst_done;

    logic fifo_nempty, wb_req, enq, head_gnt, wb_gnt;

    assign fifo_nempty   = (count_q != '0);
    assign arb_stall_req = (wait_q == WW'(MAX_WAIT));
    assign wb_req        = wb_write_enable && (wb_write_sel != 5'd0);
    // rst_done keeps lu_ready low while in reset and for the release cycle
    assign lu_ready      = rst_done && (count_q < CW'(DEPTH));
    assign enq           = lu_valid && lu_ready && (lu_sel != 5'd0);
    assign fifo_count    = count_q;

    assign head_gnt = rst && fifo_nempty && (arb_stall_req || !wb_req);
    assign wb_gnt   = rst && wb_req && !head_gnt;

    assign rf_write_enable = head_gnt || wb_gnt;
    assign rf_write_sel    = head_gnt ? sel_q[rd_ptr]  : (wb_gnt ? wb_write_sel  : 5'd0);
    assign rf_write_data   = head_gnt ? data_q[rd_ptr] : (wb_gnt ? wb_write_data : '0);

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i]) pending_mask[sel_q[i]] = 1'b1;
    end

    always_comb begin
        vld_nxt = vld_q;
        if (head_gnt) vld_nxt[rd_ptr] = 1'b0;
        if (enq)      vld_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i]  <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            vld_q    <= vld_nxt;
            if (enq) begin
                sel_q[wr_ptr]  <= lu_sel;
                data_q[wr_ptr] <= lu_data;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (head_gnt) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, head_gnt})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Counts edges the head spends blocked; reaching MAX_WAIT forces the grant
            if (!fifo_nempty || head_gnt)
                wait_q <= '0;
            else if (wait_q != WW'(MAX_WAIT))
                wait_q <= wait_q + WW'(1);
        end
    end

    a_no_wb_during_stall: assert property (@(posedge clk) disable iff (!rst)
        !(arb_stall_req && wb_req));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (XLEN=32, DEPTH=2, MAX_WAIT=4).
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbe = 1'b0;
    logic [4:0]  wbs = '0;
    logic [31:0] wbd = '0;
    logic        luv = 1'b0;
    logic        lur;
    logic [4:0]  lus = '0;
    logic [31:0] lud = '0;
    logic        rfe;
    logic [4:0]  rfs;
    logic [31:0] rfd;
    logic        stall;
    logic [31:0] pmask;
    logic [1:0]  cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.XLEN(32), .DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_write_enable(wbe), .wb_write_sel(wbs), .wb_write_data(wbd),
        .lu_valid(luv), .lu_ready(lur), .lu_sel(lus), .lu_data(lud),
        .rf_write_enable(rfe), .rf_write_sel(rfs), .rf_write_data(rfd),
        .arb_stall_req(stall), .pending_mask(pmask), .fifo_count(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_ready", 32'(lur), 0);
        chk("rst_we", 32'(rfe), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_pmask", pmask, 0);
        #2 rst = 1'b1;
        #1 chk("rel_ready_low", 32'(lur), 0);
        tick();
        chk("rel_ready_high", 32'(lur), 1);

        // Idle drain
        luv = 1; lus = 5; lud = 32'h1234;
        #1;
        chk("idle_pre_we", 32'(rfe), 0);
        tick();
        luv = 0;
        #1;
        chk("idle_we", 32'(rfe), 1);
        chk("idle_sel", 32'(rfs), 5);
        chk("idle_data", rfd, 32'h1234);
        chk("idle_pmask", pmask, 32'h20);
        chk("idle_cnt1", 32'(cnt), 1);
        tick();
        chk("idle_pmask0", pmask, 0);
        chk("idle_cnt0", 32'(cnt), 0);
        chk("idle_we0", 32'(rfe), 0);

        // Priority and starvation
        wbe = 1; wbs = 1; wbd = 32'hAAAA;
        luv = 1; lus = 7; lud = 32'h7777;
        #1;
        chk("starv_e0_sel", 32'(rfs), 1);
        tick();
        luv = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("starv_wb_sel", 32'(rfs), 1);
            chk("starv_wb_data", rfd, 32'hAAAA);
            chk("starv_nostall", 32'(stall), 0);
            chk("starv_pmask", pmask, 32'h80);
            tick();
        end
        wbe = 0;
        #1;
        chk("starv_stall", 32'(stall), 1);
        chk("starv_head_we", 32'(rfe), 1);
        chk("starv_head_sel", 32'(rfs), 7);
        chk("starv_head_data", rfd, 32'h7777);
        tick();
        chk("starv_stall_clr", 32'(stall), 0);
        chk("starv_cnt0", 32'(cnt), 0);
        chk("starv_pmask0", pmask, 0);

        // Full FIFO with lu_valid held
        wbe = 1; wbs = 2; wbd = 32'h2222;
        luv = 1; lus = 8; lud = 32'h8888;
        #1;
        chk("full_rdy0", 32'(lur), 1);
        tick();
        lus = 9; lud = 32'h9999;
        #1;
        chk("full_rdy1", 32'(lur), 1);
        chk("full_cnt1", 32'(cnt), 1);
        chk("full_wb_sel", 32'(rfs), 2);
        tick();
        lus = 10; lud = 32'hA0A0;
        #1;
        chk("full_rdy_low", 32'(lur), 0);
        chk("full_cnt2", 32'(cnt), 2);
        chk("full_pmask", pmask, 32'h300);
        tick();
        chk("full_held_cnt", 32'(cnt), 2);
        chk("full_held_rdy", 32'(lur), 0);
        wbe = 0;
        #1;
        chk("full_head8_sel", 32'(rfs), 8);
        chk("full_head8_data", rfd, 32'h8888);
        tick();
        chk("full_cnt_after8", 32'(cnt), 1);
        chk("full_rdy_again", 32'(lur), 1);
        chk("full_head9_sel", 32'(rfs), 9);
        chk("full_pmask9", pmask, 32'h200);
        tick();
        luv = 0;
        #1;
        chk("full_enqdeq_cnt", 32'(cnt), 1);
        chk("full_head10_sel", 32'(rfs), 10);
        chk("full_head10_data", rfd, 32'hA0A0);
        chk("full_pmask10", pmask, 32'h400);
        tick();
        chk("full_cnt_end", 32'(cnt), 0);
        chk("full_pmask_end", pmask, 0);

        // x0 handling
        luv = 1; lus = 0; lud = 32'hDEAD;
        #1;
        chk("x0_ready", 32'(lur), 1);
        tick();
        luv = 0;
        #1;
        chk("x0_cnt", 32'(cnt), 0);
        chk("x0_we", 32'(rfe), 0);
        chk("x0_pmask", pmask, 0);
        wbe = 1; wbs = 3; wbd = 32'h3333;
        luv = 1; lus = 6; lud = 32'h6666;
        tick();
        luv = 0; wbs = 0; wbd = 32'hBAD0;
        #1;
        chk("x0_wb_cnt", 32'(cnt), 1);
        chk("x0_wb_pmask", pmask, 32'h40);
        chk("x0_wb_we", 32'(rfe), 1);
        chk("x0_wb_sel", 32'(rfs), 6);
        chk("x0_wb_data", rfd, 32'h6666);
        tick();
        chk("x0_wb_cnt0", 32'(cnt), 0);

        // Reset mid-operation
        wbe = 1; wbs = 1; wbd = 32'h1111;
        luv = 1; lus = 3; lud = 32'h3030;
        tick();
        lus = 4; lud = 32'h4040;
        tick();
        luv = 0;
        #1;
        chk("mid_cnt2", 32'(cnt), 2);
        chk("mid_pmask", pmask, 32'h18);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(cnt), 0);
        chk("mid_rst_pmask", pmask, 0);
        chk("mid_rst_ready", 32'(lur), 0);
        chk("mid_rst_we", 32'(rfe), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        wbe = 0;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(lur), 0);
        chk("mid_rel_we", 32'(rfe), 0);
        tick();
        chk("mid_post_ready", 32'(lur), 1);
        chk("mid_post_we", 32'(rfe), 0);
        chk("mid_post_cnt", 32'(cnt), 0);
        tick();
        chk("mid_post_we2", 32'(rfe), 0);
        chk("mid_post_pmask", pmask, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
